// File: rtl/channel_tx_if.sv
// Bundle of the channel_tx request/payload, far-end acknowledges and the two-wire line.
// The master modport is the transmitter side; slave is the environment that requests frames and acks symbols.
interface channel_tx_if #(
    parameter int WIDTH = 8
);
    logic             request;
    logic [WIDTH-1:0] data_in;
    logic             fs_ack;
    logic             one_ack;
    logic             zero_ack;
    logic             fe_ack;
    logic             Ch1;
    logic             Ch2;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       state_dbg;

    modport master (
        input  request, data_in, fs_ack, one_ack, zero_ack, fe_ack,
        output Ch1, Ch2, busy, done, error, state_dbg
    );

    modport slave (
        output request, data_in, fs_ack, one_ack, zero_ack, fe_ack,
        input  Ch1, Ch2, busy, done, error, state_dbg
    );
endinterface

// File: rtl/channel_tx.sv
// Two-wire return-to-zero frame transmitter: frame start, WIDTH data symbols MSB first, frame end,
// each symbol acknowledged by the far end through a 2-flop synchronized 4-phase handshake.
module channel_tx #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic          Clk,
    input  logic          Reset,
    channel_tx_if.master  bus
);
    // Handshake: request is a strobe sampled only in IDLE (no ready; ignored while busy).
    // Each symbol is a 4-phase exchange: line drives symbol -> matching ack rises -> line 00
    // -> every ack low -> next symbol. Any foreign ack during a drive, or a stall, lands in ERR.
    typedef enum logic [2:0] {
        IDLE, FS_DRIVE, FS_RTZ, BIT_DRIVE, BIT_RTZ, FE_DRIVE, FE_RTZ, ERR
    } state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // Ack vectors are ordered {fe, zero, one, fs}.
    logic [3:0]       ack_meta;
    logic [3:0]       ack_sync;
    logic [3:0]       exp_mask;
    logic             exp_hit;
    logic             wrong_ack;
    logic             any_ack;
    logic             tmo_hit;
    logic             bit_nxt;
    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shl;
    logic [CW-1:0]    bit_cnt;
    logic [TW-1:0]    tmo;
    logic [1:0]       line_q;
    logic [1:0]       line_nxt;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    assign sreg_shl  = sreg << 1;
    assign any_ack   = |ack_sync;
    assign exp_hit   = |(ack_sync & exp_mask);
    assign wrong_ack = |(ack_sync & ~exp_mask);
    assign tmo_hit   = (tmo == TW'(TIMEOUT - 1));
    assign bit_nxt   = (state == BIT_RTZ) ? sreg_shl[WIDTH-1] : sreg[WIDTH-1];

    always_comb begin
        exp_mask = 4'b0000;
        case (state)
            FS_DRIVE:  exp_mask = 4'b0001;
            BIT_DRIVE: exp_mask = sreg[WIDTH-1] ? 4'b0010 : 4'b0100;
            FE_DRIVE:  exp_mask = 4'b1000;
            default:   exp_mask = 4'b0000;
        endcase
    end

    // A foreign ack beats the expected one; timeout only matters when nothing else moved us.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:      if (bus.request) nxt = FS_DRIVE;
            FS_DRIVE:  if (wrong_ack) nxt = ERR; else if (exp_hit) nxt = FS_RTZ;  else if (tmo_hit) nxt = ERR;
            BIT_DRIVE: if (wrong_ack) nxt = ERR; else if (exp_hit) nxt = BIT_RTZ; else if (tmo_hit) nxt = ERR;
            FE_DRIVE:  if (wrong_ack) nxt = ERR; else if (exp_hit) nxt = FE_RTZ;  else if (tmo_hit) nxt = ERR;
            FS_RTZ:    if (!any_ack) nxt = BIT_DRIVE; else if (tmo_hit) nxt = ERR;
            BIT_RTZ:   if (!any_ack) nxt = (bit_cnt == '0) ? FE_DRIVE : BIT_DRIVE;
                       else if (tmo_hit) nxt = ERR;
            FE_RTZ:    if (!any_ack) nxt = IDLE; else if (tmo_hit) nxt = ERR;
            default:   nxt = ERR;
        endcase
    end

    always_comb begin
        line_nxt = 2'b00;
        case (nxt)
            FS_DRIVE, FE_DRIVE: line_nxt = 2'b11;
            BIT_DRIVE:          line_nxt = bit_nxt ? 2'b10 : 2'b01;
            default:            line_nxt = 2'b00;
        endcase
    end

    // Outputs are registered from the next state so the line changes on the same edge as the state.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ack_meta <= '0;
            ack_sync <= '0;
            state    <= IDLE;
            sreg     <= '0;
            bit_cnt  <= '0;
            tmo      <= '0;
            line_q   <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            ack_meta <= {bus.fe_ack, bus.zero_ack, bus.one_ack, bus.fs_ack};
            ack_sync <= ack_meta;
            state    <= nxt;
            line_q   <= line_nxt;
            busy_q   <= (nxt != IDLE);
            done_q   <= (state == FE_RTZ) && (nxt == IDLE);
            error_q  <= (nxt == ERR);
            if (nxt != state)
                tmo <= '0;
            else if (state != IDLE && state != ERR)
                tmo <= tmo + 1'b1;
            if (state == IDLE && bus.request) begin
                sreg    <= bus.data_in;
                bit_cnt <= CW'(WIDTH - 1);
            end else if (state == BIT_RTZ && nxt == BIT_DRIVE) begin
                sreg    <= sreg_shl;
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    assign bus.Ch1       = line_q[1];
    assign bus.Ch2       = line_q[0];
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_channel_tx.sv
// Bench for channel_tx: an ack responder drives frames while a monitor pops the expected line
// symbols from a queue built from the frame-level model; directed cases cover errors, timeout and reset.
module tb_channel_tx;
    localparam int W   = 8;
    localparam int TMO = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    channel_tx_if #(.WIDTH(W)) bus ();

    channel_tx #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    int         done_cnt = 0;
    bit         sb_en    = 1'b0;
    logic [1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame model: symbol i=0 is frame start, 1..W the data bits MSB first, W+1 frame end.
    function automatic logic [1:0] sym_code(input logic [W-1:0] d, input int i);
        if (i == 0 || i == W + 1) return 2'b11;
        return d[W-i] ? 2'b10 : 2'b01;
    endfunction

    // 0 = fs_ack, 1 = one_ack, 2 = zero_ack, 3 = fe_ack
    function automatic int sym_ack(input logic [W-1:0] d, input int i);
        if (i == 0) return 0;
        if (i == W + 1) return 3;
        return d[W-i] ? 1 : 2;
    endfunction

    function automatic void push_frame(input logic [W-1:0] d);
        for (int i = 0; i < W + 2; i++) begin
            exp_q.push_back(sym_code(d, i));
            exp_q.push_back(2'b00);
        end
    endfunction

    task automatic set_ack(input int a, input logic v);
        case (a)
            0:       bus.fs_ack   = v;
            1:       bus.one_ack  = v;
            2:       bus.zero_ack = v;
            default: bus.fe_ack   = v;
        endcase
    endtask

    task automatic clear_inputs();
        bus.request  = 1'b0;
        bus.fs_ack   = 1'b0;
        bus.one_ack  = 1'b0;
        bus.zero_ack = 1'b0;
        bus.fe_ack   = 1'b0;
    endtask

    task automatic wait_line(input logic [1:0] v, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if ({bus.Ch1, bus.Ch2} == v) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL wait_line: line %b never reached %b at %0t", {bus.Ch1, bus.Ch2}, v, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Counts edges from an ack/stimulus change until the line returns to 00.
    task automatic edges_to_zero(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while ({bus.Ch1, bus.Ch2} != 2'b00 && n < 20);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input int abort_at, input bit hold_rtz);
        int  n;
        int  a;
        int  done_before;
        bit  ok;
        done_before = done_cnt;
        push_frame(d);
        @(negedge clk);
        bus.data_in = d;
        bus.request = 1'b1;
        @(negedge clk);
        bus.request = 1'b0;
        bus.data_in = W'($urandom);
        check("start_line", {bus.Ch1, bus.Ch2}, 2'b11);
        check("start_busy", bus.busy, 1'b1);
        for (int i = 0; i < W + 2; i++) begin
            a = sym_ack(d, i);
            wait_line(sym_code(d, i), ok);
            if (!ok) return;
            if (i == 1) begin
                bus.data_in = ~d;
                bus.request = 1'b1;
                @(negedge clk);
                bus.request = 1'b0;
            end
            if (i == abort_at) begin
                repeat (2) @(negedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("abort_line", {bus.Ch1, bus.Ch2}, 2'b00);
                check("abort_busy", bus.busy, 1'b0);
                check("abort_error", bus.error, 1'b0);
                check("abort_done", bus.done, 1'b0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            set_ack(a, 1'b1);
            edges_to_zero(n);
            check("ack_to_rtz_edges", n, 3);
            @(negedge clk);
            if (hold_rtz && a == 1) begin
                hold_rtz = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    check("hold_rtz_line", {bus.Ch1, bus.Ch2}, 2'b00);
                    check("hold_rtz_error", bus.error, 1'b0);
                end
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            set_ack(a, 1'b0);
        end
        n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("end_busy", bus.busy, 1'b0);
        @(negedge clk);
        check("end_done_count", done_cnt, done_before + 1);
        check("end_error", bus.error, 1'b0);
        check("end_queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: every line change is compared with the next modelled symbol.
    initial begin
        logic [1:0] line;
        logic [1:0] last_line;
        logic       prev_done;
        last_line = 2'b00;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                last_line = 2'b00;
                prev_done = 1'b0;
            end else begin
                line = {bus.Ch1, bus.Ch2};
                if (sb_en && line != last_line) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL line_unexpected: got %b with no symbol expected at %0t", line, $time);
                    end else begin
                        check("line_symbol", line, exp_q.pop_front());
                    end
                end
                if (bus.done) begin
                    done_cnt++;
                    check("done_width", prev_done, 1'b0);
                end
                prev_done = bus.done;
                last_line = line;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d;
        int           n;
        int           done_before;
        bit           ok;

        rst_n       = 1'b0;
        bus.data_in = '0;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("reset_line", {bus.Ch1, bus.Ch2}, 2'b00);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_error", bus.error, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", bus.busy, 1'b0);

        sb_en = 1'b1;
        send_frame(8'hA5, -1, 1'b0);
        for (int f = 0; f < 6; f++) begin
            d = W'($urandom);
            send_frame(d, -1, 1'b0);
        end
        send_frame(8'h3C, -1, 1'b1);

        // Foreign ack during a 1-bit drive: alone, then together with the expected ack.
        sb_en = 1'b0;
        for (int m = 0; m < 2; m++) begin
            done_before = done_cnt;
            d = 8'h80 | W'($urandom_range(0, 127));
            @(negedge clk);
            bus.data_in = d;
            bus.request = 1'b1;
            @(negedge clk);
            bus.request = 1'b0;
            wait_line(2'b11, ok);
            bus.fs_ack = 1'b1;
            @(negedge clk);
            wait_line(2'b00, ok);
            bus.fs_ack = 1'b0;
            @(negedge clk);
            wait_line(2'b10, ok);
            bus.zero_ack = 1'b1;
            if (m == 1) bus.one_ack = 1'b1;
            n = 0;
            do begin
                @(posedge clk);
                #1 n++;
            end while (!bus.error && n < 20);
            check("err_edges", n, 3);
            check("err_line", {bus.Ch1, bus.Ch2}, 2'b00);
            check("err_busy", bus.busy, 1'b1);
            clear_inputs();
            repeat (20) @(negedge clk);
            check("err_held", bus.error, 1'b1);
            check("err_no_done", done_cnt, done_before);
            do_reset();
            check("err_cleared", bus.error, 1'b0);
        end

        // No ack at all after frame start.
        @(negedge clk);
        bus.data_in = W'($urandom);
        bus.request = 1'b1;
        @(negedge clk);
        bus.request = 1'b0;
        check("tmo_start_line", {bus.Ch1, bus.Ch2}, 2'b11);
        n = 0;
        do begin
            @(posedge clk);
            #1 n++;
        end while (!bus.error && n < TMO + 20);
        check("tmo_edges", n, TMO);
        check("tmo_line", {bus.Ch1, bus.Ch2}, 2'b00);
        do_reset();
        sb_en = 1'b1;
        send_frame(8'hFF, -1, 1'b0);

        // Reset during the 4th data bit, then a fresh all-zero frame.
        sb_en = 1'b0;
        done_before = done_cnt;
        send_frame(W'($urandom), 4, 1'b0);
        exp_q.delete();
        clear_inputs();
        @(negedge clk);
        check("abort_no_done", done_cnt, done_before);
        sb_en = 1'b1;
        send_frame(8'h00, -1, 1'b0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/channel_tx.md
CHANNEL_TX -- requirements
Module: channel_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving bits per frame.
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait in any handshake state.
REQ-003 The block SHALL have port Clk, input, 1 bit, the single system clock (rising edge).
REQ-004 The block SHALL have port Reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port request, input, 1 bit, a start-frame request sampled only in IDLE.
REQ-006 The block SHALL have port data_in, input, WIDTH bits, the frame payload captured when request is accepted.
REQ-007 The block SHALL have ports fs_ack, one_ack, zero_ack and fe_ack, each an input, 1 bit, an asynchronous acknowledge from the far-end receiver.
REQ-008 The block SHALL have ports Ch1 and Ch2, each an output, 1 bit, the registered two-wire line.
REQ-009 The block SHALL have port busy, output, 1 bit, high in every state except IDLE.
REQ-010 The block SHALL have port done, output, 1 bit, a one-cycle pulse on frame completion.
REQ-011 The block SHALL have port error, output, 1 bit, high while in ERR.

Function
REQ-012 Each ack input SHALL pass through a 2-flop synchronizer before any use; the FSM SHALL see only the synchronized values.
REQ-013 Line encoding SHALL be: idle/return-to-zero = Ch1,Ch2 00; frame start and frame end = 11; data 1 = 10; data 0 = 01.
REQ-014 The FSM states SHALL be IDLE, FS_DRIVE, FS_RTZ, BIT_DRIVE, BIT_RTZ, FE_DRIVE, FE_RTZ and ERR.
REQ-015 In IDLE, request=1 at a rising edge SHALL capture data_in into a shift register, load the bit counter with WIDTH-1, and enter FS_DRIVE.
REQ-016 Ch1/Ch2 SHALL be registered from the next state, so the line shows the new symbol on the same edge as the state change.
REQ-017 FS_DRIVE SHALL drive 11 and, on synchronized fs_ack=1, go to FS_RTZ.
REQ-018 Every *_RTZ state SHALL drive 00 and leave only when all four synchronized acks are 0.
REQ-019 FS_RTZ SHALL exit to BIT_DRIVE.
REQ-020 BIT_DRIVE SHALL drive the MSB of the shift register (MSB first) and wait for one_ack if the bit is 1, or zero_ack if the bit is 0, then go to BIT_RTZ.
REQ-021 When BIT_RTZ exits with counter=0, the FSM SHALL go to FE_DRIVE.
REQ-022 When BIT_RTZ exits with counter>0, the FSM SHALL shift left, decrement the counter, and return to BIT_DRIVE.
REQ-023 FE_DRIVE SHALL drive 11 and, on fe_ack=1, go to FE_RTZ.
REQ-024 FE_RTZ SHALL exit to IDLE and pulse done for exactly 1 cycle on the edge that enters IDLE.
REQ-025 In any *_DRIVE state, any synchronized ack other than the expected one SHALL force ERR; this includes the case where it is asserted together with the expected ack, since error has priority.
REQ-026 A timeout counter SHALL clear on every state entry and increment each cycle in DRIVE/RTZ states.
REQ-027 When the timeout counter reaches TIMEOUT, the FSM SHALL go to ERR.
REQ-028 ERR SHALL drive 00 with error=1 and busy=1, and SHALL be left only by Reset.
REQ-029 request while busy=1 SHALL be ignored; data_in changes after capture SHALL have no effect.
REQ-030 Latency from request accepted to Ch=11 SHALL be 1 edge.
REQ-031 Latency from an ack rising to the line changing SHALL be exactly 3 rising edges (2 synchronizer + 1 FSM).
REQ-032 A frame SHALL comprise exactly WIDTH+2 symbols, each followed by a return-to-zero.

Reset
REQ-033 Reset=0 SHALL asynchronously force IDLE, Ch1=Ch2=0, busy=0, done=0 and error=0, and clear the synchronizers, shift register and counters.
REQ-034 Reset asserted mid-frame SHALL abort the frame immediately with the line at 00; no done pulse SHALL be issued.
REQ-035 After Reset deasserts, the first request SHALL start a fresh frame.

Verification
REQ-036 WIDTH=8, data_in=0xA5, responder model acks each symbol and drops after RTZ -> line sequence 11,10,01,10,00... bits 1,0,1,0,0,1,0,1 then 11; one done pulse; busy low after.
REQ-037 The bench SHALL raise fs_ack while in FS_DRIVE -> Ch goes 00 exactly 3 edges later; second request while busy -> ignored, frame unaffected.
REQ-038 During BIT_DRIVE for a 1 bit, assert zero_ack -> error=1, line 00, ERR held until Reset; no done pulse.
REQ-039 No ack after FS_DRIVE entry -> ERR after exactly TIMEOUT cycles (255 by default); then Reset -> IDLE, new frame with 0xFF completes.
REQ-040 Reset pulsed low during the 4th data bit -> outputs zero immediately; next request with 0x00 sends 11, eight 01 symbols, 11.
REQ-041 Hold one_ack high into BIT_RTZ for 10 cycles -> FSM stays in BIT_RTZ with line 00 until the ack drops, with no timeout when TIMEOUT > 10.
